// File: rtl/vk_cdc_pkg.sv
// vk_cdc_pkg: shared types for the toggle-handshake bus crossing.
// Receiver FSM state encoding lives here.
package vk_cdc_pkg;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_HOLD
    } cdc_rx_state_t;

endpackage

// File: rtl/vk_clock_sync_v2.sv
// vk_clock_sync_v2: DEPTH-stage flop-chain synchronizer.
// Synchronous active-low reset loads INIT_VAL into every stage.
module vk_clock_sync_v2 #(
    parameter int              WIDTH    = 1,
    parameter int              DEPTH    = 2,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [DEPTH];

    // shift the asynchronous input through the chain
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_chain[i] <= INIT_VAL;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/vk_cdc_bus_rx.sv
// vk_cdc_bus_rx: destination side of a toggle-handshake bus crossing.
// src_data and src_req_tgl need a timing exception; data relies on source hold.
module vk_cdc_bus_rx
    import vk_cdc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SYNC_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             dst_clk,
    input  logic             rstn,
    input  logic             src_req_tgl,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_ack_tgl,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready,
    output logic             proto_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int ARM_CYCLES = SYNC_DEPTH + 1;
    localparam int ARM_CNT_W  = $clog2(SYNC_DEPTH + 2);
    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(ARM_CYCLES - 1);

    logic                 w_req_sync;
    cdc_rx_state_t        r_state;
    logic [ARM_CNT_W-1:0] r_arm_cnt;
    logic                 r_req_seen;
    logic                 r_ack_tgl;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic                 r_proto_err;
    logic [CNT_W-1:0]     r_xfer_cnt;

    vk_clock_sync_v2 #(
        .WIDTH    (1),
        .DEPTH    (SYNC_DEPTH),
        .INIT_VAL (1'b0)
    ) u_req_sync (
        .i_clk  (dst_clk),
        .i_rstn (rstn),
        .i_d    (src_req_tgl),
        .o_q    (w_req_sync)
    );

    // ARM absorbs any toggle pending at reset, then IDLE/HOLD move words
    always_ff @(posedge dst_clk) begin
        if (!rstn) begin
            r_state     <= ST_ARM;
            r_arm_cnt   <= '0;
            r_req_seen  <= 1'b0;
            r_ack_tgl   <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_proto_err <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            unique case (r_state)
                ST_ARM: begin
                    r_req_seen <= w_req_sync;
                    r_ack_tgl  <= w_req_sync;
                    if (r_arm_cnt == ARM_LAST) begin
                        r_arm_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_req_sync != r_req_seen) begin
                        r_data     <= src_data;
                        r_req_seen <= w_req_sync;
                        r_valid    <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // second toggle before ack: flag it, service it later
                    if (w_req_sync != r_req_seen) begin
                        r_proto_err <= 1'b1;
                    end
                    if (dst_ready) begin
                        r_valid    <= 1'b0;
                        r_ack_tgl  <= ~r_ack_tgl;
                        r_xfer_cnt <= r_xfer_cnt + 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

    assign dst_ack_tgl = r_ack_tgl;
    assign dst_valid   = r_valid;
    assign dst_data    = r_data;
    assign proto_err   = r_proto_err;
    assign xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_vk_cdc_bus_rx.sv
// tb_vk_cdc_bus_rx: scoreboard bench for the toggle-handshake receiver.
// Counter width is reduced to 4 so the wrap case stays short.
module tb_vk_cdc_bus_rx;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          dst_clk = 1'b0;
    logic          rstn;
    logic          src_req_tgl;
    logic [W-1:0]  src_data;
    logic          dst_ack_tgl;
    logic          dst_valid;
    logic [W-1:0]  dst_data;
    logic          dst_ready;
    logic          proto_err;
    logic [CW-1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_q[$];
    logic          ack_exp;
    logic [CW-1:0] cnt_exp;

    vk_cdc_bus_rx #(
        .WIDTH      (W),
        .SYNC_DEPTH (2),
        .CNT_W      (CW)
    ) dut (
        .dst_clk     (dst_clk),
        .rstn        (rstn),
        .src_req_tgl (src_req_tgl),
        .src_data    (src_data),
        .dst_ack_tgl (dst_ack_tgl),
        .dst_valid   (dst_valid),
        .dst_data    (dst_data),
        .dst_ready   (dst_ready),
        .proto_err   (proto_err),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 dst_clk = ~dst_clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dst_clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] w);
        src_data    = w;
        src_req_tgl = ~src_req_tgl;
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dst_valid && n < 20);
        chk(name, n, lat);
    endtask

    task automatic handshake(input string name);
        dst_ready = 1'b1;
        tick();
        ack_exp = ~ack_exp;
        cnt_exp = cnt_exp + 1'b1;
        chk({name, "_valid_fall"}, dst_valid, 0);
        chk({name, "_ack"}, dst_ack_tgl, ack_exp);
        chk({name, "_cnt"}, xfer_cnt, cnt_exp);
    endtask

    // monitor: a word is consumed on the next edge when valid && ready
    always @(negedge dst_clk) begin
        if (rstn && dst_valid && dst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", dst_data, 'x);
            end else begin
                chk("sb_data", dst_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] held;
        logic         stable;

        rstn        = 1'b0;
        src_req_tgl = 1'b0;
        src_data    = '0;
        dst_ready   = 1'b0;
        ack_exp     = 1'b0;
        cnt_exp     = '0;

        // reset then idle
        repeat (4) tick();
        chk("rst_valid", dst_valid, 0);
        chk("rst_data", dst_data, 0);
        chk("rst_ack", dst_ack_tgl, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_cnt", xfer_cnt, 0);
        rstn = 1'b1;
        stable = 1'b1;
        repeat (6) begin
            tick();
            if (dst_valid) stable = 1'b0;
        end
        chk("idle_no_valid", stable, 1);

        // single transfer, ready already high on the capture edge
        dst_ready = 1'b1;
        launch(32'hDEADBEEF);
        wait_valid("single_lat", 3);
        chk("single_data", dst_data, 32'hDEADBEEF);
        handshake("single");

        // backpressure for 10 cycles
        dst_ready = 1'b0;
        tick();
        launch(32'h12345678);
        wait_valid("bp_lat", 3);
        held = dst_data;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!dst_valid || dst_data !== held || dst_ack_tgl !== ack_exp)
                stable = 1'b0;
        end
        chk("bp_hold", stable, 1);
        chk("bp_data", held, 32'h12345678);
        handshake("bp");

        // protocol error: two toggles 8 cycles apart without ready
        dst_ready = 1'b0;
        tick();
        launch(32'hA5A5A5A5);
        wait_valid("pe_lat", 3);
        repeat (5) tick();
        launch(32'h5A5A5A5A);
        repeat (3) tick();
        chk("pe_flag", proto_err, 1);
        chk("pe_held", dst_data, 32'hA5A5A5A5);
        handshake("pe_first");
        tick();
        chk("pe_second_valid", dst_valid, 1);
        chk("pe_second_data", dst_data, 32'h5A5A5A5A);
        handshake("pe_second");
        chk("pe_sticky", proto_err, 1);

        // reset with a pending request
        dst_ready = 1'b0;
        rstn = 1'b0;
        src_req_tgl = ~src_req_tgl;
        repeat (4) tick();
        rstn = 1'b1;
        chk("rr_err_clr", proto_err, 0);
        chk("rr_cnt_clr", xfer_cnt, 0);
        ack_exp = src_req_tgl;
        cnt_exp = '0;
        stable = 1'b1;
        repeat (3) begin
            tick();
            if (dst_valid) stable = 1'b0;
        end
        chk("rr_arm_ack", dst_ack_tgl, ack_exp);
        repeat (4) begin
            tick();
            if (dst_valid) stable = 1'b0;
        end
        chk("rr_no_valid", stable, 1);
        chk("rr_err", proto_err, 0);

        // counter wrap: 17 transfers on a 4-bit counter
        dst_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            launch(32'h1000_0000 + i);
            wait_valid("wrap_lat", 3);
            handshake("wrap");
        end
        chk("wrap_final", xfer_cnt, 1);

        repeat (3) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vk_cdc_bus_rx.md
# vk_cdc_bus_rx

Destination-side receiver of a toggle-handshake multi-bit bus crossing. It synchronizes the source's request toggle into dst_clk and captures the source-held data word. It presents the word downstream on a valid/ready interface and returns an acknowledge toggle to the source once the word is consumed. It sits directly downstream of the source-domain launch logic and embeds a flop-chain synchronizer for the request toggle.

## Interface
- WIDTH, 32, data word width
- SYNC_DEPTH, 2, synchronizer flop stages on src_req_tgl (≥2)
- CNT_W, 16, width of transfer counter
- dst_clk  in  1  destination clock
- rstn  in  1  reset, synchronous, active-low
- src_req_tgl  in  1  request toggle from source domain (asynchronous)
- src_data  in  WIDTH  source data; held stable by source from req toggle until ack toggle seen
- dst_ack_tgl  out  1  acknowledge toggle to source domain, registered in dst_clk
- dst_valid  out  1  word available downstream
- dst_data  out  WIDTH  captured word, stable while dst_valid
- dst_ready  in  1  downstream accepts word
- proto_err  out  1  sticky protocol-violation flag
- xfer_cnt  out  CNT_W  completed transfers, wraps

## Operation
- src_req_tgl passes through a SYNC_DEPTH-stage synchronizer (reset value 0), giving req_sync. req_seen register holds the last serviced toggle level.
- FSM states: ARM, IDLE, HOLD.
- ARM: entered on reset. Each cycle, req_seen <= req_sync and dst_ack_tgl <= req_sync. The detector is disabled. After SYNC_DEPTH+1 cycles in ARM, go to IDLE; a small counter of width $clog2(SYNC_DEPTH+2) times this. A request pending at reset is therefore discarded and acknowledged.
- IDLE: when req_sync != req_seen: dst_data <= src_data, req_seen <= req_sync, dst_valid <= 1, go to HOLD.
- HOLD: dst_valid=1, dst_data frozen. On dst_valid && dst_ready: dst_valid <= 0, dst_ack_tgl <= ~dst_ack_tgl, xfer_cnt <= xfer_cnt+1 (mod 2^CNT_W), go to IDLE.
- Protocol error: if req_sync != req_seen while in HOLD, the source toggled twice without an ack. proto_err <= 1 and stays set until reset. The held word is kept, and the extra toggle is serviced after return to IDLE.
- dst_valid never drops without a handshake, except on reset.

## Timing
- Reset values: dst_valid 0, dst_data 0, dst_ack_tgl 0, proto_err 0, xfer_cnt 0, FSM ARM, synchronizer 0, req_seen 0.
- Latency: src_req_tgl changes before edge E1. req_sync changes after edge E_SYNC_DEPTH. dst_valid rises after edge E_SYNC_DEPTH+1, which is 3 edges for the default.
- Ack: dst_ack_tgl toggles on the same edge that completes the valid/ready handshake. dst_valid falls on that edge too.
- Back-to-back: the earliest next capture is the edge after the return to IDLE, gated by the source round trip. IDLE is at least one cycle.
- dst_ready held high in IDLE has no effect. dst_ready high on the capture edge does not complete a transfer; the minimum HOLD is one cycle.
- Reset mid-HOLD: the word is dropped with no ack toggle, then the ARM sequence runs.
- xfer_cnt wraps from 2^CNT_W−1 to 0 without flagging.

## Structure
- Package vk_cdc_pkg: typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_HOLD} cdc_rx_state_t; localparam ARM_CYCLES = SYNC_DEPTH+1 is derived locally.
- Sub-module: vk_clock_sync_v2 with WIDTH=1, DEPTH=SYNC_DEPTH, INIT_VAL=0 for src_req_tgl.
- No data synchronization: src_data is sampled directly, relying on source hold. Apply a timing exception on src_data and src_req_tgl.

## Test plan
- Reset then idle: rstn low for 4 cycles, src_req_tgl=0 -> all outputs 0; IDLE reached after 3 cycles from release; no dst_valid.
- Single transfer: src_data=0xDEADBEEF, toggle req to 1, dst_ready=1 -> dst_valid high after 3 edges with dst_data=0xDEADBEEF. One cycle later, ack toggles to 1 and xfer_cnt=1.
- Backpressure: dst_ready=0 for 10 cycles after valid -> dst_valid and dst_data stable and no ack toggle; ack toggles on the edge where dst_ready rises.
- Protocol error: toggle req twice, 8 cycles apart, while dst_ready=0 -> proto_err=1 sticky, first word held. After ready, the second word is delivered and xfer_cnt=2.
- Reset with pending request: req=1 at reset release -> no dst_valid; dst_ack_tgl=1 at the end of ARM; proto_err=0.
- Counter wrap with CNT_W=4: 17 transfers -> xfer_cnt=1.
